// File: rtl/pe_conv1d_pkg.sv
// Shared types and helpers for the 1-D convolution processing element:
// FSM state encoding, width helpers and saturation bounds.
package pe_conv1d_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_MAC,
    ST_OUTPUT,
    ST_DONE
  } state_e;

  // Counter/tag width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int out_len(input int act, input int kern, input int stride);
    return (act - kern) / stride + 1;
  endfunction

  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/pe_conv1d_engine_if.sv
// Load, control and result handshake bundle of the convolution engine.
interface pe_conv1d_engine_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FILT_W     = 1,
  parameter int POS_W      = 3
);
  logic                  load_valid;
  logic                  load_sel;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  load_done;
  logic                  cfg_relu;
  logic                  start;
  logic                  busy;
  logic                  compute_done;
  logic                  err;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [FILT_W-1:0]     out_filter;
  logic [POS_W-1:0]      out_pos;

  modport master (
    output load_valid, load_sel, load_data, cfg_relu, start, out_ready,
    input  load_ready, load_done, busy, compute_done, err,
           out_valid, out_data, out_filter, out_pos
  );

  modport slave (
    input  load_valid, load_sel, load_data, cfg_relu, start, out_ready,
    output load_ready, load_done, busy, compute_done, err,
           out_valid, out_data, out_filter, out_pos
  );

endinterface

// File: rtl/pe_dual_spad.sv
// Weight and activation scratchpads: one write port and one synchronous
// read port each, read data valid the cycle after the read enable.
module pe_dual_spad #(
  parameter int DATA_WIDTH = 16,
  parameter int W_DEPTH    = 6,
  parameter int A_DEPTH    = 8,
  parameter int WAW        = 3,
  parameter int AAW        = 3
) (
  input  logic                  clk,
  input  logic                  w_we_i,
  input  logic [WAW-1:0]        w_waddr_i,
  input  logic [DATA_WIDTH-1:0] w_wdata_i,
  input  logic                  w_re_i,
  input  logic [WAW-1:0]        w_raddr_i,
  output logic [DATA_WIDTH-1:0] w_rdata_o,
  input  logic                  a_we_i,
  input  logic [AAW-1:0]        a_waddr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  input  logic                  a_re_i,
  input  logic [AAW-1:0]        a_raddr_i,
  output logic [DATA_WIDTH-1:0] a_rdata_o
);

  logic [DATA_WIDTH-1:0] w_mem [W_DEPTH];
  logic [DATA_WIDTH-1:0] a_mem [A_DEPTH];
  logic [DATA_WIDTH-1:0] w_rdata_q;
  logic [DATA_WIDTH-1:0] a_rdata_q;

  always_ff @(posedge clk) begin
    if (w_we_i) w_mem[w_waddr_i] <= w_wdata_i;
    if (w_re_i) w_rdata_q <= w_mem[w_raddr_i];
  end

  always_ff @(posedge clk) begin
    if (a_we_i) a_mem[a_waddr_i] <= a_wdata_i;
    if (a_re_i) a_rdata_q <= a_mem[a_raddr_i];
  end

  assign w_rdata_o = w_rdata_q;
  assign a_rdata_o = a_rdata_q;

endmodule

// File: rtl/pe_conv1d_engine.sv
// 1-D convolution engine: loads filters/activations in IDLE, then computes
// every (filter, position) output with one MAC per cycle and hands it out.
module pe_conv1d_engine
  import pe_conv1d_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 40,
  parameter int KERNEL_SIZE = 3,
  parameter int ACT_SIZE    = 8,
  parameter int NUM_FILTERS = 2,
  parameter int STRIDE      = 1
) (
  input  logic              clk,
  input  logic              reset,
  pe_conv1d_engine_if.slave bus
);

  localparam int OUT_LEN = out_len(ACT_SIZE, KERNEL_SIZE, STRIDE);
  localparam int W_DEPTH = NUM_FILTERS * KERNEL_SIZE;
  localparam int WAW     = clog2_min1(W_DEPTH);
  localparam int AAW     = clog2_min1(ACT_SIZE);
  localparam int FW      = clog2_min1(NUM_FILTERS);
  localparam int PW      = clog2_min1(OUT_LEN);
  localparam int KW      = clog2_min1(KERNEL_SIZE);

  localparam logic [WAW-1:0] W_LAST = WAW'(W_DEPTH - 1);
  localparam logic [AAW-1:0] A_LAST = AAW'(ACT_SIZE - 1);
  localparam logic [FW-1:0]  F_LAST = FW'(NUM_FILTERS - 1);
  localparam logic [PW-1:0]  O_LAST = PW'(OUT_LEN - 1);
  localparam logic [KW-1:0]  K_LAST = KW'(KERNEL_SIZE - 1);

  localparam longint SAT_MAX = sat_max(DATA_WIDTH);
  localparam longint SAT_MIN = sat_min(DATA_WIDTH);

  state_e                       state_q, state_d;
  logic [WAW-1:0]               w_ptr_q, w_ptr_d;
  logic [AAW-1:0]               a_ptr_q, a_ptr_d;
  logic                         w_loaded_q, w_loaded_d;
  logic                         a_loaded_q, a_loaded_d;
  logic                         relu_q, relu_d;
  logic                         load_done_q, load_done_d;
  logic                         err_q, err_d;
  logic                         out_valid_q, out_valid_d;
  logic [FW-1:0]                f_q, f_d;
  logic [PW-1:0]                o_q, o_d;
  logic [KW-1:0]                k_q, k_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;

  logic                         w_we, a_we, rd_en;
  int                           tap;
  logic [WAW-1:0]               w_raddr;
  logic [AAW-1:0]               a_raddr;
  logic [DATA_WIDTH-1:0]        w_rdata, a_rdata;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [63:0]           acc_wide;
  logic [DATA_WIDTH-1:0]        sat_res;

  pe_dual_spad #(
    .DATA_WIDTH (DATA_WIDTH),
    .W_DEPTH    (W_DEPTH),
    .A_DEPTH    (ACT_SIZE),
    .WAW        (WAW),
    .AAW        (AAW)
  ) u_spad (
    .clk       (clk),
    .w_we_i    (w_we),
    .w_waddr_i (w_ptr_q),
    .w_wdata_i (bus.load_data),
    .w_re_i    (rd_en),
    .w_raddr_i (w_raddr),
    .w_rdata_o (w_rdata),
    .a_we_i    (a_we),
    .a_waddr_i (a_ptr_q),
    .a_wdata_i (bus.load_data),
    .a_re_i    (rd_en),
    .a_raddr_i (a_raddr),
    .a_rdata_o (a_rdata)
  );

  assign w_raddr  = WAW'(int'(f_q) * KERNEL_SIZE + tap);
  assign a_raddr  = AAW'(int'(o_q) * STRIDE + tap);
  assign prod     = $signed(w_rdata) * $signed(a_rdata);
  assign acc_wide = 64'(acc_q);

  // Clamp to the output range first, then apply the optional ReLU.
  always_comb begin
    sat_res = acc_q[DATA_WIDTH-1:0];
    if (acc_wide > SAT_MAX) begin
      sat_res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (acc_wide < SAT_MIN) begin
      sat_res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
    if (relu_q && sat_res[DATA_WIDTH-1]) sat_res = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      w_ptr_q     <= '0;
      a_ptr_q     <= '0;
      w_loaded_q  <= 1'b0;
      a_loaded_q  <= 1'b0;
      relu_q      <= 1'b0;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      f_q         <= '0;
      o_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      w_ptr_q     <= w_ptr_d;
      a_ptr_q     <= a_ptr_d;
      w_loaded_q  <= w_loaded_d;
      a_loaded_q  <= a_loaded_d;
      relu_q      <= relu_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      f_q         <= f_d;
      o_q         <= o_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
    end
  end

  // FETCH issues tap 0; each MAC cycle consumes the previous read and issues
  // the next, and OUTPUT spends its first cycle registering the result.
  always_comb begin
    state_d     = state_q;
    w_ptr_d     = w_ptr_q;
    a_ptr_d     = a_ptr_q;
    w_loaded_d  = w_loaded_q;
    a_loaded_d  = a_loaded_q;
    relu_d      = relu_q;
    load_done_d = 1'b0;
    err_d       = 1'b0;
    out_valid_d = out_valid_q;
    f_d         = f_q;
    o_d         = o_q;
    k_d         = k_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    w_we        = 1'b0;
    a_we        = 1'b0;
    rd_en       = 1'b0;
    tap         = 0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.load_valid) begin
          if (!bus.load_sel) begin
            w_we = 1'b1;
            if (w_ptr_q == W_LAST) begin
              w_ptr_d     = '0;
              w_loaded_d  = 1'b1;
              load_done_d = 1'b1;
            end else begin
              w_ptr_d = w_ptr_q + 1'b1;
            end
          end else begin
            a_we = 1'b1;
            if (a_ptr_q == A_LAST) begin
              a_ptr_d     = '0;
              a_loaded_d  = 1'b1;
              load_done_d = 1'b1;
            end else begin
              a_ptr_d = a_ptr_q + 1'b1;
            end
          end
        end else if (bus.start) begin
          if (w_loaded_q && a_loaded_q) begin
            state_d = ST_FETCH;
            f_d     = '0;
            o_d     = '0;
            relu_d  = bus.cfg_relu;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_FETCH: begin
        rd_en   = 1'b1;
        acc_d   = '0;
        k_d     = '0;
        state_d = ST_MAC;
      end

      ST_MAC: begin
        tap   = int'(k_q) + 1;
        rd_en = (k_q != K_LAST);
        acc_d = acc_q + ACC_WIDTH'(prod);
        if (k_q == K_LAST) begin
          state_d = ST_OUTPUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      ST_OUTPUT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = sat_res;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (o_q == O_LAST) begin
            o_d = '0;
            if (f_q == F_LAST) begin
              f_d     = '0;
              state_d = ST_DONE;
            end else begin
              f_d     = f_q + 1'b1;
              state_d = ST_FETCH;
            end
          end else begin
            o_d     = o_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.load_ready   = (state_q == ST_IDLE);
  assign bus.busy         = (state_q inside {ST_FETCH, ST_MAC, ST_OUTPUT});
  assign bus.compute_done = (state_q == ST_DONE);
  assign bus.load_done    = load_done_q;
  assign bus.err          = err_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_filter   = f_q;
  assign bus.out_pos      = o_q;

endmodule

// File: tb/tb_pe_conv1d_engine.sv
// Two engine configurations (K3/A5/F1/S1 and K3/A7/F2/S2) share one stimulus
// bus selected by 'sel'; expected results come from a reference model queue.
module tb_pe_conv1d_engine;

  localparam int DW  = 16;
  localparam int K   = 3;
  localparam int A_A = 5;
  localparam int S_A = 1;
  localparam int A_B = 7;
  localparam int F_B = 2;
  localparam int S_B = 2;

  typedef struct {
    logic [15:0] data;
    logic [0:0]  filt;
    logic [1:0]  pos;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  logic load_valid = 1'b0;
  logic load_sel = 1'b0;
  logic [15:0] load_data = '0;
  logic cfg_relu = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int lastWait = 0;
  longint wm [6];
  longint am [7];
  exp_t sb [$];

  always #5 clk = ~clk;

  pe_conv1d_engine_if #(.DATA_WIDTH(DW), .FILT_W(1), .POS_W(2)) if_a ();
  pe_conv1d_engine_if #(.DATA_WIDTH(DW), .FILT_W(1), .POS_W(2)) if_b ();

  assign if_a.load_valid = load_valid & ~sel;
  assign if_b.load_valid = load_valid & sel;
  assign if_a.start      = start & ~sel;
  assign if_b.start      = start & sel;
  assign if_a.out_ready  = out_ready & ~sel;
  assign if_b.out_ready  = out_ready & sel;
  assign if_a.load_sel   = load_sel;
  assign if_b.load_sel   = load_sel;
  assign if_a.load_data  = load_data;
  assign if_b.load_data  = load_data;
  assign if_a.cfg_relu   = cfg_relu;
  assign if_b.cfg_relu   = cfg_relu;

  logic m_load_ready, m_busy, m_out_valid, m_load_done, m_compute_done, m_err;
  logic [15:0] m_out_data;
  logic [0:0]  m_out_filter;
  logic [1:0]  m_out_pos;

  assign m_load_ready   = sel ? if_b.load_ready   : if_a.load_ready;
  assign m_busy         = sel ? if_b.busy         : if_a.busy;
  assign m_out_valid    = sel ? if_b.out_valid    : if_a.out_valid;
  assign m_load_done    = sel ? if_b.load_done    : if_a.load_done;
  assign m_compute_done = sel ? if_b.compute_done : if_a.compute_done;
  assign m_err          = sel ? if_b.err          : if_a.err;
  assign m_out_data     = sel ? if_b.out_data     : if_a.out_data;
  assign m_out_filter   = sel ? if_b.out_filter   : if_a.out_filter;
  assign m_out_pos      = sel ? if_b.out_pos      : if_a.out_pos;

  pe_conv1d_engine #(
    .DATA_WIDTH(DW), .ACC_WIDTH(40), .KERNEL_SIZE(K),
    .ACT_SIZE(A_A), .NUM_FILTERS(1), .STRIDE(S_A)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  pe_conv1d_engine #(
    .DATA_WIDTH(DW), .ACC_WIDTH(40), .KERNEL_SIZE(K),
    .ACT_SIZE(A_B), .NUM_FILTERS(F_B), .STRIDE(S_B)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [15:0] d);
    load_valid = 1'b1;
    load_sel   = s;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic loadWeights(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'(wm[i]));
    checkOutput("w_load_done", 32'(m_load_done), 1);
  endtask

  task automatic loadActs(input int n, input bit withStart);
    for (int i = 0; i < n; i++) begin
      if (withStart && i == 0) start = 1'b1;
      applyStimulus(1'b1, 16'(am[i]));
      start = 1'b0;
      if (withStart && i == 0) begin
        checkOutput("load_beats_start_err", 32'(m_err), 0);
        checkOutput("load_beats_start_busy", 32'(m_busy), 0);
      end
    end
    checkOutput("a_load_done", 32'(m_load_done), 1);
  endtask

  // Reference: full-precision dot product, clamp, then ReLU.
  function automatic logic [15:0] model(input int f, input int o, input bit relu,
                                        input int ss);
    longint acc = 0;
    for (int k = 0; k < K; k++) acc += wm[f*K + k] * am[o*ss + k];
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return 16'(acc);
  endfunction

  task automatic pushRun(input int nf, input int ss, input bit relu);
    exp_t e;
    for (int f = 0; f < nf; f++) begin
      for (int o = 0; o < 3; o++) begin
        e.data = model(f, o, relu, ss);
        e.filt = 1'(f);
        e.pos  = 2'(o);
        sb.push_back(e);
      end
    end
  endtask

  task automatic startRun(input bit relu);
    cfg_relu = relu;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    cfg_relu = ~relu;
    checkOutput("busy_after_start", 32'(m_busy), 1);
  endtask

  task automatic collect(input int n, input int stall);
    exp_t e;
    int waited;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      while (!m_out_valid && waited < 40) begin
        tick();
        waited++;
      end
      if (i == 0) lastWait = waited;
      checkOutput("out_valid_timeout", 32'(m_out_valid), 1);
      if (sb.size() == 0) begin
        checkOutput("scoreboard_underflow", 32'(sb.size()), 1);
      end else begin
        e = sb.pop_front();
        checkOutput("out_data", 32'(m_out_data), 32'(e.data));
        checkOutput("out_filter", 32'(m_out_filter), 32'(e.filt));
        checkOutput("out_pos", 32'(m_out_pos), 32'(e.pos));
        for (int s = 0; s < stall; s++) begin
          tick();
          checkOutput("stall_valid", 32'(m_out_valid), 1);
          checkOutput("stall_data", 32'(m_out_data), 32'(e.data));
          checkOutput("stall_pos", 32'(m_out_pos), 32'(e.pos));
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic finishRun();
    checkOutput("compute_done_pulse", 32'(m_compute_done), 1);
    checkOutput("busy_in_done", 32'(m_busy), 0);
    tick();
    checkOutput("compute_done_clear", 32'(m_compute_done), 0);
    checkOutput("ready_after_done", 32'(m_load_ready), 1);
    checkOutput("scoreboard_drained", 32'(sb.size()), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tick();
    tick();
    checkOutput("rst_load_ready", 32'(m_load_ready), 1);
    checkOutput("rst_busy", 32'(m_busy), 0);
    checkOutput("rst_out_valid", 32'(m_out_valid), 0);
    checkOutput("rst_out_data", 32'(m_out_data), 0);
    checkOutput("rst_err", 32'(m_err), 0);
    reset = 1'b0;

    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("err_no_loads", 32'(m_err), 1);
    checkOutput("busy_no_loads", 32'(m_busy), 0);
    tick();
    checkOutput("err_one_cycle", 32'(m_err), 0);

    // Basic run; a load word and start are held during it and must be ignored.
    wm[0] = 1; wm[1] = 2; wm[2] = 3;
    for (int i = 0; i < A_A; i++) am[i] = i + 1;
    loadWeights(K);
    loadActs(A_A, 1'b1);
    pushRun(1, S_A, 1'b0);
    startRun(1'b0);
    load_valid = 1'b1; load_sel = 1'b0; load_data = 16'd99; start = 1'b1;
    checkOutput("no_ready_in_run", 32'(m_load_ready), 0);
    collect(1, 0);
    checkOutput("first_latency", 32'(lastWait), K + 2);
    load_valid = 1'b0; start = 1'b0;
    collect(2, 0);
    checkOutput("next_latency", 32'(lastWait), K + 2);
    finishRun();

    wm[0] = -1; wm[1] = -1; wm[2] = -1;
    loadWeights(K);
    pushRun(1, S_A, 1'b0);
    startRun(1'b0);
    collect(3, 0);
    finishRun();
    pushRun(1, S_A, 1'b1);
    startRun(1'b1);
    collect(3, 0);
    finishRun();

    for (int i = 0; i < K; i++) wm[i] = 32767;
    for (int i = 0; i < A_A; i++) am[i] = 32767;
    loadWeights(K);
    loadActs(A_A, 1'b0);
    pushRun(1, S_A, 1'b0);
    startRun(1'b0);
    collect(3, 0);
    finishRun();
    for (int i = 0; i < K; i++) wm[i] = -32768;
    loadWeights(K);
    pushRun(1, S_A, 1'b0);
    startRun(1'b0);
    collect(3, 0);
    finishRun();

    startRun(1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("midrun_rst_busy", 32'(m_busy), 0);
    checkOutput("midrun_rst_valid", 32'(m_out_valid), 0);
    checkOutput("midrun_rst_ready", 32'(m_load_ready), 1);
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("err_after_rst", 32'(m_err), 1);
    checkOutput("busy_after_rst", 32'(m_busy), 0);

    sel = 1'b1;
    wm[0] = 1; wm[1] = 0; wm[2] = -1; wm[3] = 2; wm[4] = 1; wm[5] = 1;
    am[0] = 3; am[1] = -2; am[2] = 5; am[3] = 7; am[4] = -4; am[5] = 1; am[6] = 6;
    loadWeights(F_B * K);
    loadActs(A_B, 1'b0);
    pushRun(F_B, S_B, 1'b0);
    startRun(1'b0);
    collect(1, 5);
    checkOutput("b_first_latency", 32'(lastWait), K + 2);
    collect(5, 0);
    finishRun();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
